// File: rtl/approx_mon_pkg.sv
// approx_mon_pkg
//   Shared definitions for the approximate-adder error monitor:
//   - state_t   : sweep FSM states
//   - err_cnt_w : width of the nonzero-error vector counter
//   - sum_err_w : width of the summed absolute error
package approx_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Up to 2^in_w vectors can be in error, so one extra bit is needed.
  function automatic int err_cnt_w(input int in_w);
    return in_w + 1;
  endfunction

  // Worst case is 2^in_w vectors each at the maximum (2^out_w - 1) error.
  function automatic int sum_err_w(input int in_w, input int out_w);
    return in_w + out_w;
  endfunction

endpackage

// File: rtl/exact_abs_err.sv
// exact_abs_err
//   Combinational reference operator: splits vec into two operands,
//   computes the exact sum and returns its absolute distance from the
//   approximate result. Replace this block to check other operators.
// Ports:
//   vec    in  IN_W   input vector, a = low half, b = high half
//   approx in  OUT_W  approximate circuit result
//   e      out OUT_W  |exact - approx|
module exact_abs_err #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3
) (
  input  logic [IN_W-1:0]  vec,
  input  logic [OUT_W-1:0] approx,
  output logic [OUT_W-1:0] e
);

  localparam int HALF = IN_W / 2;

  logic [HALF-1:0]  op_a;
  logic [HALF-1:0]  op_b;
  logic [OUT_W-1:0] exact;

  assign op_a  = vec[HALF-1:0];
  assign op_b  = vec[IN_W-1:HALF];
  assign exact = OUT_W'(op_a) + OUT_W'(op_b);

  // Compare first so the subtraction never underflows.
  assign e = (exact >= approx) ? (exact - approx) : (approx - exact);

endmodule

// File: rtl/approx_error_monitor.sv
// approx_error_monitor
//   Sweeps every input vector through an external approximate adder,
//   compares each response with the exact sum and accumulates error
//   statistics (worst case, count, sum, first vector over threshold).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a sweep (only honoured while idle)
//   vec_o         vector presented to the approximate circuit
//   vec_valid     vec_o is awaiting a response
//   approx_i      approximate result for vec_o
//   approx_valid  approx_i is valid (only taken while vec_valid=1)
//   busy, done    sweep in progress / sweep finished (held until next start)
//   max_err, err_cnt, sum_err, fail_vec, violation, timeout : results
module approx_error_monitor
  import approx_mon_pkg::*;
#(
  parameter int IN_W         = 4,
  parameter int OUT_W        = 3,
  parameter int ET           = 5,
  parameter int TIMEOUT      = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [IN_W-1:0]                vec_o,
  output logic                           vec_valid,
  input  logic [OUT_W-1:0]               approx_i,
  input  logic                           approx_valid,
  output logic                           busy,
  output logic                           done,
  output logic [OUT_W-1:0]               max_err,
  output logic [err_cnt_w(IN_W)-1:0]     err_cnt,
  output logic [sum_err_w(IN_W, OUT_W)-1:0] sum_err,
  output logic [IN_W-1:0]                fail_vec,
  output logic                           violation,
  output logic                           timeout
);

  localparam int CNT_W  = err_cnt_w(IN_W);
  localparam int SUM_W  = sum_err_w(IN_W, OUT_W);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t             state_reg;
  logic [IN_W-1:0]    vec_cnt_reg;
  logic [WAIT_W-1:0]  wait_reg;
  logic [OUT_W-1:0]   approx_reg;
  logic               vec_valid_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [OUT_W-1:0]   max_err_reg;
  logic [CNT_W-1:0]   err_cnt_reg;
  logic [SUM_W-1:0]   sum_err_reg;
  logic [IN_W-1:0]    fail_vec_reg;
  logic               violation_reg;
  logic               timeout_reg;

  logic [OUT_W-1:0]   e;
  logic               over;
  logic               last_vec;

  // Error of the vector captured in DRIVE; only consumed in EVAL.
  exact_abs_err #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_exact_abs_err (
    .vec    (vec_cnt_reg),
    .approx (approx_reg),
    .e      (e)
  );

  assign over     = (32'(e) > ET);
  assign last_vec = (vec_cnt_reg == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      vec_cnt_reg   <= '0;
      wait_reg      <= '0;
      approx_reg    <= '0;
      vec_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      max_err_reg   <= '0;
      err_cnt_reg   <= '0;
      sum_err_reg   <= '0;
      fail_vec_reg  <= '0;
      violation_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            vec_cnt_reg   <= '0;
            wait_reg      <= '0;
            max_err_reg   <= '0;
            err_cnt_reg   <= '0;
            sum_err_reg   <= '0;
            fail_vec_reg  <= '0;
            violation_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b1;
            vec_valid_reg <= 1'b1;
            state_reg     <= DRIVE;
          end
        end

        DRIVE: begin
          // vec_valid is always high here, so approx_valid alone marks a transfer.
          if (approx_valid) begin
            approx_reg    <= approx_i;
            vec_valid_reg <= 1'b0;
            state_reg     <= EVAL;
          end else if (wait_reg == WAIT_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th cycle without a response.
            timeout_reg   <= 1'b1;
            vec_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            wait_reg <= wait_reg + WAIT_W'(1);
          end
        end

        EVAL: begin
          if (e > max_err_reg) max_err_reg <= e;
          sum_err_reg <= sum_err_reg + SUM_W'(e);
          if (e != '0) err_cnt_reg <= err_cnt_reg + CNT_W'(1);
          if (over) begin
            violation_reg <= 1'b1;
            if (!violation_reg) fail_vec_reg <= vec_cnt_reg;
          end

          if (last_vec || (STOP_ON_FAIL && over)) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            vec_cnt_reg   <= vec_cnt_reg + IN_W'(1);
            wait_reg      <= '0;
            vec_valid_reg <= 1'b1;
            state_reg     <= DRIVE;
          end
        end

        DONE: begin
          // done_reg stays set into IDLE until the next accepted start.
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign vec_o     = vec_cnt_reg;
  assign vec_valid = vec_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign max_err   = max_err_reg;
  assign err_cnt   = err_cnt_reg;
  assign sum_err   = sum_err_reg;
  assign fail_vec  = fail_vec_reg;
  assign violation = violation_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_approx_error_monitor.sv
module tb_approx_error_monitor;

  localparam int IN_W  = 4;
  localparam int OUT_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start_s;

  // Main instance (STOP_ON_FAIL=0)
  logic [IN_W-1:0]  vec_o;
  logic             vec_valid;
  logic [OUT_W-1:0] approx_i;
  logic             approx_valid;
  logic             busy, done, violation, timeout;
  logic [OUT_W-1:0] max_err;
  logic [4:0]       err_cnt;
  logic [6:0]       sum_err;
  logic [IN_W-1:0]  fail_vec;

  // Stop-on-fail instance
  logic [IN_W-1:0]  vec_o_s;
  logic             vec_valid_s;
  logic [OUT_W-1:0] approx_i_s;
  logic             approx_valid_s;
  logic             busy_s, done_s, violation_s, timeout_s;
  logic [OUT_W-1:0] max_err_s;
  logic [4:0]       err_cnt_s;
  logic [6:0]       sum_err_s;
  logic [IN_W-1:0]  fail_vec_s;

  approx_error_monitor #(
    .IN_W(IN_W), .OUT_W(OUT_W), .ET(5), .TIMEOUT(16), .STOP_ON_FAIL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .vec_o(vec_o), .vec_valid(vec_valid),
    .approx_i(approx_i), .approx_valid(approx_valid),
    .busy(busy), .done(done), .max_err(max_err), .err_cnt(err_cnt),
    .sum_err(sum_err), .fail_vec(fail_vec), .violation(violation),
    .timeout(timeout)
  );

  approx_error_monitor #(
    .IN_W(IN_W), .OUT_W(OUT_W), .ET(5), .TIMEOUT(16), .STOP_ON_FAIL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start_s),
    .vec_o(vec_o_s), .vec_valid(vec_valid_s),
    .approx_i(approx_i_s), .approx_valid(approx_valid_s),
    .busy(busy_s), .done(done_s), .max_err(max_err_s), .err_cnt(err_cnt_s),
    .sum_err(sum_err_s), .fail_vec(fail_vec_s), .violation(violation_s),
    .timeout(timeout_s)
  );

  // Responder modes: 0 exact, 1 constant 0, 3 never valid, 4 exact+1 after 3 wait cycles
  int mode = 0;
  logic [1:0] lat = 2'd0;
  logic [OUT_W-1:0] exact_sum;

  always @(posedge clk) begin
    if (!vec_valid || approx_valid) lat <= 2'd0;
    else lat <= lat + 2'd1;
  end

  always_comb begin
    exact_sum    = {1'b0, vec_o[1:0]} + {1'b0, vec_o[3:2]};
    approx_i     = exact_sum;
    approx_valid = vec_valid;
    case (mode)
      1: approx_i = 3'd0;
      3: approx_valid = 1'b0;
      4: begin
        approx_i     = exact_sum + 3'd1;
        approx_valid = vec_valid && (lat == 2'd3);
      end
      default: ;
    endcase
  end

  assign approx_i_s     = 3'd7;
  assign approx_valid_s = vec_valid_s;

  // vec_o must not move between DRIVE cycles that had no transfer
  int unstable = 0;
  logic prev_valid = 1'b0, prev_xfer = 1'b0;
  logic [IN_W-1:0] prev_vec = '0;
  always @(negedge clk) begin
    if (vec_valid && prev_valid && !prev_xfer && vec_o !== prev_vec) unstable <= unstable + 1;
    prev_valid <= vec_valid;
    prev_xfer  <= approx_valid;
    prev_vec   <= vec_o;
  end

  int checks = 0;
  int failures = 0;

  task automatic run_sweep(input int mid_at, output int bc, output bit ok);
    ok = 1'b0;
    bc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (busy) bc++;
      start = (busy && bc == mid_at) ? 1'b1 : 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({vec_o, vec_valid, busy, done, max_err, err_cnt, sum_err, fail_vec, violation, timeout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: vec_o=%0d vv=%b busy=%b done=%b max=%0d cnt=%0d sum=%0d fv=%0d viol=%b to=%b, required all 0",
               vec_o, vec_valid, busy, done, max_err, err_cnt, sum_err, fail_vec, violation, timeout);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: outputs idle");
  endtask

  task automatic test_exact();
    int bc; bit ok;
    mode = 0;
    run_sweep(-1, bc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL exact_done: done never rose within bound"); end
    checks++; if (bc !== 32) begin failures++; $display("FAIL exact_busy_cycles: got %0d required 32", bc); end
    checks++;
    if (max_err !== 3'd0 || err_cnt !== 5'd0 || sum_err !== 7'd0 || violation !== 1'b0 || fail_vec !== 4'd0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL exact_stats: max=%0d cnt=%0d sum=%0d viol=%b fv=%0d to=%b, required 0 0 0 0 0 0",
               max_err, err_cnt, sum_err, violation, fail_vec, timeout);
    end
    $display("sweep exact: busy=%0d max=%0d cnt=%0d sum=%0d", bc, max_err, err_cnt, sum_err);
  endtask

  task automatic test_const_zero();
    int bc; bit ok;
    mode = 1;
    run_sweep(-1, bc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_done: done never rose within bound"); end
    checks++; if (max_err !== 3'd6) begin failures++; $display("FAIL zero_max_err: got %0d required 6", max_err); end
    checks++; if (err_cnt !== 5'd15) begin failures++; $display("FAIL zero_err_cnt: got %0d required 15", err_cnt); end
    checks++; if (sum_err !== 7'd48) begin failures++; $display("FAIL zero_sum_err: got %0d required 48", sum_err); end
    checks++; if (violation !== 1'b1) begin failures++; $display("FAIL zero_violation: got %b required 1", violation); end
    checks++; if (fail_vec !== 4'd15) begin failures++; $display("FAIL zero_fail_vec: got %0d required 15", fail_vec); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL zero_timeout: got %b required 0", timeout); end
    $display("sweep const0: max=%0d cnt=%0d sum=%0d fv=%0d", max_err, err_cnt, sum_err, fail_vec);
  endtask

  task automatic test_stop_on_fail();
    int bc; bit ok;
    bc = 0; ok = 1'b0;
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy_s) bc++;
      if (done_s) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin failures++; $display("FAIL stop_done: done never rose within bound"); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL stop_busy_cycles: got %0d required 2", bc); end
    checks++;
    if (max_err_s !== 3'd7 || err_cnt_s !== 5'd1 || sum_err_s !== 7'd7 || fail_vec_s !== 4'd0 || violation_s !== 1'b1) begin
      failures++;
      $display("FAIL stop_stats: max=%0d cnt=%0d sum=%0d fv=%0d viol=%b, required 7 1 7 0 1",
               max_err_s, err_cnt_s, sum_err_s, fail_vec_s, violation_s);
    end
    $display("sweep stop_on_fail: busy=%0d max=%0d cnt=%0d sum=%0d", bc, max_err_s, err_cnt_s, sum_err_s);
  endtask

  task automatic test_timeout();
    int bc; bit ok;
    mode = 3;
    run_sweep(-1, bc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL to_done: done never rose within bound"); end
    checks++; if (bc !== 16) begin failures++; $display("FAIL to_busy_cycles: got %0d required 16", bc); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_flag: got %b required 1", timeout); end
    checks++;
    if (max_err !== 3'd0 || err_cnt !== 5'd0 || sum_err !== 7'd0 || violation !== 1'b0 || fail_vec !== 4'd0) begin
      failures++;
      $display("FAIL to_stats: max=%0d cnt=%0d sum=%0d viol=%b fv=%0d, required all 0",
               max_err, err_cnt, sum_err, violation, fail_vec);
    end
    $display("sweep timeout: busy=%0d to=%b", bc, timeout);
  endtask

  task automatic test_latency();
    int bc; bit ok;
    int unstable_before;
    mode = 4;
    unstable_before = unstable;
    run_sweep(-1, bc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL lat_done: done never rose within bound"); end
    checks++; if (bc !== 80) begin failures++; $display("FAIL lat_busy_cycles: got %0d required 80", bc); end
    checks++;
    if (max_err !== 3'd1 || err_cnt !== 5'd16 || sum_err !== 7'd16 || violation !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL lat_stats: max=%0d cnt=%0d sum=%0d viol=%b to=%b, required 1 16 16 0 0",
               max_err, err_cnt, sum_err, violation, timeout);
    end
    checks++; if (unstable !== unstable_before) begin failures++; $display("FAIL lat_vec_stable: %0d changes while waiting, required 0", unstable - unstable_before); end
    $display("sweep latency3: busy=%0d max=%0d cnt=%0d sum=%0d", bc, max_err, err_cnt, sum_err);
  endtask

  task automatic test_reset_midsweep();
    int bc; bit ok;
    mode = 1;
    ok = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (vec_valid && vec_o == 4'd7) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin failures++; $display("FAIL mid_reach_vec7: vector 7 never presented"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({vec_o, vec_valid, busy, done, max_err, err_cnt, sum_err, fail_vec, violation, timeout} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: vec_o=%0d vv=%b busy=%b done=%b max=%0d cnt=%0d sum=%0d fv=%0d viol=%b to=%b, required all 0",
               vec_o, vec_valid, busy, done, max_err, err_cnt, sum_err, fail_vec, violation, timeout);
    end
    mode = 0;
    run_sweep(10, bc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_done: done never rose within bound"); end
    checks++; if (bc !== 32) begin failures++; $display("FAIL mid_busy_cycles: got %0d required 32", bc); end
    checks++;
    if (max_err !== 3'd0 || err_cnt !== 5'd0 || sum_err !== 7'd0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL mid_stats: max=%0d cnt=%0d sum=%0d to=%b, required 0 0 0 0", max_err, err_cnt, sum_err, timeout);
    end
    $display("sweep after reset with ignored start: busy=%0d done=%b", bc, done);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_const_zero();
    test_stop_on_fail();
    test_timeout();
    test_latency();
    test_reset_midsweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_error_monitor.md
Name: approx_error_monitor

Overview:
- Sequential checker at the far end of an approximate-adder netlist: it generates every input vector, receives the approximate circuit's output, and compares it against the exact sum.
- Reports worst-case error, error count, summed error, first failing vector and threshold violation.
- Used in-silicon or in-bench to confirm that a synthesized approximate adder honours its error threshold.

Parameters:
- IN_W, 4, total input bits to the adder under check; operand a = vec[IN_W/2-1:0], operand b = vec[IN_W-1:IN_W/2]; must be even, ≥2.
- OUT_W, 3, adder output width; must equal IN_W/2+1.
- ET, 5, error threshold; violation when |exact-approx| > ET.
- TIMEOUT, 16, maximum cycles to wait for a response per vector.
- STOP_ON_FAIL, 0, 1 = finish at the first vector whose error exceeds ET.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a sweep; sampled only in IDLE
- vec_o  out  IN_W  current input vector presented to the approximate circuit
- vec_valid  out  1  vec_o is valid and awaiting a response
- approx_i  in  OUT_W  approximate circuit output for vec_o
- approx_valid  in  1  approx_i is valid; accepted only while vec_valid=1
- busy  out  1  sweep in progress
- done  out  1  sweep finished; held until the next accepted start
- max_err  out  OUT_W  largest absolute error seen
- err_cnt  out  IN_W+1  number of vectors with nonzero error
- sum_err  out  IN_W+OUT_W  sum of absolute errors
- fail_vec  out  IN_W  first vector with error > ET; 0 if none
- violation  out  1  some error > ET
- timeout  out  1  sweep aborted for lack of a response

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, including vec_o, vec_valid, busy, done and all statistics. Reset asserted mid-sweep aborts immediately, with the same values.
- IDLE: start=1 clears all statistics, done, violation and timeout; sets vec counter=0; goes to DRIVE next cycle. busy=1 from that cycle on.
- DRIVE:
  - vec_valid=1, vec_o=counter.
  - A transfer occurs on a cycle with vec_valid & approx_valid. approx_i is registered and the FSM goes to EVAL.
  - The wait counter increments each DRIVE cycle without a transfer. When it reaches TIMEOUT, timeout=1 and the FSM goes to DONE without evaluating the vector.
- EVAL (one cycle, vec_valid=0):
  - exact = a+b, OUT_W bits; e = |exact - approx|, OUT_W bits, unsigned compare-and-subtract.
  - max_err = max(max_err, e); sum_err += e; err_cnt += (e≠0).
  - If e > ET: violation=1, and fail_vec=counter if this is the first violation.
  - Then the FSM goes to DONE if counter = 2^IN_W-1, or if STOP_ON_FAIL and e > ET. Otherwise counter++, wait counter cleared, and the FSM goes to DRIVE.
- DONE: busy=0, done=1 for one state cycle, then IDLE. done stays high in IDLE until the next accepted start.
- Throughput: 2 cycles per vector minimum, when approx_valid=1 in the first DRIVE cycle. A full IN_W=4 sweep takes 32 cycles from the first DRIVE to DONE.
- start while busy is ignored. approx_valid outside DRIVE is ignored.
- The counter never wraps; termination is by the last-vector check.
- Statistics do not saturate; the widths cover the worst case: err_cnt ≤ 2^IN_W, sum_err ≤ 2^IN_W·(2^OUT_W-1).

Decomposition:
- Package approx_mon_pkg holds:
  - state enum: IDLE, DRIVE, EVAL, DONE;
  - width helper functions for err_cnt and sum_err.
- Sub-module exact_abs_err (combinational):
  - inputs: vec, approx;
  - output: e;
  - can be swapped for other exact operators (multiplier etc.).
- Statistics registers and FSM stay in the top.

Test Plan:
- Responder returns exact a+b with zero latency → done after 32 busy cycles; max_err=0, err_cnt=0, sum_err=0, violation=0, fail_vec=0.
- Responder returns constant 0 → max_err=6, err_cnt=15, sum_err=48, violation=1, fail_vec=15, timeout=0.
- STOP_ON_FAIL=1, responder returns constant 7 → stops after vector 0; fail_vec=0, err_cnt=1, max_err=7, sum_err=7.
- approx_valid held low → timeout=1, done=1 after 16 DRIVE cycles; statistics remain 0.
- Responder returns exact+1 with 3-cycle latency on each vector → max_err=1, err_cnt=16, sum_err=16, violation=0; vec_o stable while vec_valid=1.
- rst pulsed at vector 7, then start pulsed during a later sweep's busy period → all outputs 0 after reset; the fresh sweep completes normally; the mid-sweep start has no effect.
